icache_1way: RTL and testbench
==============================

ICACHE_1WAY -- requirements
Module: icache_1way

Interface
REQ-001 SHALL have port clock_i, input, 1, single system clock; all logic rising-edge.
REQ-002 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port init_no, output, 1, low while tag store initialises, high once ready.
REQ-004 SHALL have port pc_i, input, 16, requested 32-bit-word address.
REQ-005 SHALL have port get_i, input, 1, fetch request strobe, sampled with pc_i.
REQ-006 SHALL have port hit_o, output, 1, one-cycle pulse: data_o holds the requested word.
REQ-007 SHALL have port data_o, output, 32, instruction word.
REQ-008 SHALL have port invld_i, input, 1, invalidate strobe.
REQ-009 SHALL have port iaddr_i, input, 16, word address whose line is invalidated.
REQ-010 SHALL have port read_o, output, 1, one-cycle line-fill request to memory.
REQ-011 SHALL have port full_i, input, 1, memory busy; read_o must not assert while high.
REQ-012 SHALL have port ready_i, input, 1, data_i holds a valid fill word this cycle.
REQ-013 SHALL have port addr_o, output, 16, line base address {pc[15:4],4'h0}.
REQ-014 SHALL have port data_i, input, 32, fill data from memory.

Function
REQ-015 SHALL be direct-mapped: 64 lines x 16 words; word = pc[3:0], index = pc[9:4], tag = pc[15:10]; each line has 6-bit tag and valid bit.
REQ-016 SHALL use states INIT, IDLE, LOOKUP, REQ, FILL, DONE.
REQ-017 INIT SHALL clear one valid bit per cycle, index 0..63, then enter IDLE and drive init_no high; get_i and invld_i are ignored in INIT.
REQ-018 In IDLE, get_i=1 SHALL latch pc_i and enter LOOKUP; get_i in any other state SHALL be ignored (requester re-issues after hit_o).
REQ-019 LOOKUP SHALL compare stored tag/valid: on hit, hit_o=1 and data_o=word that same cycle (one cycle after get_i), return to IDLE.
REQ-020 On miss SHALL go to REQ; in REQ, when full_i=0, assert read_o for exactly one cycle with addr_o={pc[15:4],4'h0}, then enter FILL; while full_i=1 read_o stays low.
REQ-021 addr_o SHALL remain stable from read_o until the fill completes.
REQ-022 FILL SHALL write data_i into word 0,1,...,15 of the indexed line on successive ready_i=1 cycles (gaps allowed); cycles with ready_i=0 write nothing.
REQ-023 After the 16th beat SHALL write tag and set valid, then in DONE (next cycle) assert hit_o for one cycle with data_o = requested word, return to IDLE.
REQ-024 Memory returns beats no earlier than the cycle after read_o; ready_i outside FILL SHALL be ignored.
REQ-025 invld_i (any state except INIT) SHALL clear valid of line iaddr_i[9:4] if its stored tag equals iaddr_i[15:10]; an invalidate of the line currently being filled is overridden by the fill completion.
REQ-026 If invld_i and a lookup target the same line in the same cycle, the lookup SHALL see the line invalid (miss).
REQ-027 hit_o and read_o SHALL never be high in the same cycle; hit_o SHALL never be high on consecutive cycles.
REQ-028 data_o SHALL hold its last value when hit_o=0.

Reset
REQ-029 reset_i SHALL asynchronously force state INIT, init index 0, init_no=0, hit_o=0, read_o=0, addr_o=0, data_o=0, fill counter 0.
REQ-030 Reset mid-fill SHALL abandon the fill; the partial line stays invalid (INIT clears all valids).

Verification
REQ-031 Reset 3 cycles -> init_no low >=64 cycles then high; no read_o, no hit_o.
REQ-032 Cold get_i pc=0x0014 -> read_o one cycle addr_o=0x0010; 16 beats -> hit_o pulse, data_o=mem[0x0014].
REQ-033 Then get_i pc=0x0015 -> hit_o next cycle, data_o=mem[0x0015], no read_o.
REQ-034 Conflict: pc=0x0414 (same index, tag 1) -> refill addr_o=0x0410; then pc=0x0014 misses again.
REQ-035 invld_i iaddr_i=0x0014 after line cached -> next get_i pc=0x0014 misses and refills; invld_i iaddr_i=0x0414 (tag mismatch) -> line kept.
REQ-036 full_i high 5 cycles on miss -> read_o delayed until first cycle full_i low; ready_i gaps mid-fill -> correct line contents.

Source files
------------

// File: rtl/icache_1way.sv
// ----------------------------------------------------------------------------
// icache_1way: direct-mapped instruction cache, 64 lines x 16 32-bit words.
//
// Address split (word address pc[15:0]):
//   word  = pc[3:0]    word within line
//   index = pc[9:4]    line select
//   tag   = pc[15:10]  stored per line along with a valid bit
//
// After reset the FSM walks all 64 valid bits clearing one per cycle (INIT),
// then accepts fetches. A fetch is latched in IDLE and looked up in the
// following cycle; a miss issues a single line-fill request and writes the
// 16 returned beats before presenting the requested word.
//
// Ports:
//   clock_i   system clock, rising edge
//   reset_i   asynchronous active-high reset
//   init_no   low while the tag store is being initialised, high when ready
//   pc_i      requested word address
//   get_i     fetch strobe, sampled with pc_i (only accepted in IDLE)
//   hit_o     one-cycle pulse: data_o holds the requested word
//   data_o    instruction word, holds its last value while hit_o is low
//   invld_i   invalidate strobe
//   iaddr_i   word address whose line is invalidated if its tag matches
//   read_o    one-cycle line-fill request, never asserted while full_i is high
//   full_i    memory busy
//   ready_i   data_i holds a valid fill beat this cycle
//   addr_o    line base address of the outstanding fill
//   data_i    fill data from memory
// ----------------------------------------------------------------------------
module icache_1way (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic        init_no,
    input  logic [15:0] pc_i,
    input  logic        get_i,
    output logic        hit_o,
    output logic [31:0] data_o,
    input  logic        invld_i,
    input  logic [15:0] iaddr_i,
    output logic        read_o,
    input  logic        full_i,
    input  logic        ready_i,
    output logic [15:0] addr_o,
    input  logic [31:0] data_i
);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLookup,
        StReq,
        StFill,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] data_mem [1024];
    logic [5:0]  tag_mem  [64];
    logic [63:0] valid_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e      state_q;
    logic [5:0]  init_idx_q;
    logic [15:0] pc_q;
    logic [3:0]  beat_q;
    logic [15:0] addr_q;
    logic [31:0] data_hold_q;
    logic        init_no_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [5:0] lk_idx;
    logic [5:0] lk_tag;
    logic [5:0] inv_idx;
    logic [5:0] inv_tag;
    logic       inv_en;
    logic       lookup_hit;
    logic       fill_we;
    logic       fill_last;

    // iaddr_i[3:0] selects a word; invalidation works on whole lines.
    logic unused_iaddr_word;
    assign unused_iaddr_word = ^iaddr_i[3:0];

    assign lk_idx  = pc_q[9:4];
    assign lk_tag  = pc_q[15:10];
    assign inv_idx = iaddr_i[9:4];
    assign inv_tag = iaddr_i[15:10];

    // Invalidate only acts on a line whose stored tag matches.
    assign inv_en = invld_i && (state_q != StInit) && (tag_mem[inv_idx] == inv_tag);

    // A same-cycle invalidate of the looked-up line forces a miss.
    assign lookup_hit = (state_q == StLookup) && valid_q[lk_idx] &&
                        (tag_mem[lk_idx] == lk_tag) &&
                        !(inv_en && (inv_idx == lk_idx));

    assign fill_we   = (state_q == StFill) && ready_i;
    assign fill_last = fill_we && (beat_q == 4'hf);

    // hit_o must appear in the lookup cycle itself, so it is decoded from the
    // registered state rather than registered again. DONE always hits: the
    // line was just completed and a racing invalidate loses to the fill.
    assign hit_o = lookup_hit || (state_q == StDone);

    // read_o is gated by full_i in the same cycle so it never overlaps busy.
    assign read_o = (state_q == StReq) && !full_i;

    // Word is read straight from the array on a hit; otherwise the last
    // delivered word is held.
    assign data_o  = hit_o ? data_mem[pc_q[9:0]] : data_hold_q;
    assign addr_o  = addr_q;
    assign init_no = init_no_q;

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StInit;
            init_idx_q  <= '0;
            init_no_q   <= 1'b0;
            pc_q        <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            data_hold_q <= '0;
        end else begin
            if (hit_o) begin
                data_hold_q <= data_o;
            end

            unique case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 6'd1;
                    if (init_idx_q == 6'd63) begin
                        state_q   <= StIdle;
                        init_no_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (get_i) begin
                        pc_q    <= pc_i;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (lookup_hit) begin
                        state_q <= StIdle;
                    end else begin
                        addr_q  <= {pc_q[15:4], 4'h0};
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (!full_i) begin
                        beat_q  <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (ready_i) begin
                        beat_q <= beat_q + 4'd1;
                        if (fill_last) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array writes. Valid bits are not reset directly: INIT walks them all,
    // which also discards any line whose fill was cut short by reset.
    // Order matters: a completing fill overrides an invalidate of its line.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (fill_we) begin
            data_mem[{lk_idx, beat_q}] <= data_i;
        end
        if (fill_last) begin
            tag_mem[lk_idx] <= lk_tag;
        end
    end

    always_ff @(posedge clock_i) begin
        if (state_q == StInit) begin
            valid_q[init_idx_q] <= 1'b0;
        end
        if (inv_en) begin
            valid_q[inv_idx] <= 1'b0;
        end
        if (fill_last) begin
            valid_q[lk_idx] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_hit_read_excl : assert property (@(posedge clock_i) disable iff (reset_i)
        !(hit_o && read_o));

    a_hit_not_back_to_back : assert property (@(posedge clock_i) disable iff (reset_i)
        hit_o |=> !hit_o);

    a_read_not_when_full : assert property (@(posedge clock_i) disable iff (reset_i)
        read_o |-> !full_i);

endmodule

// File: tb/tb_icache_1way.sv
module tb_icache_1way;

    logic        clock_i;
    logic        reset_i;
    logic        init_no;
    logic [15:0] pc_i;
    logic        get_i;
    logic        hit_o;
    logic [31:0] data_o;
    logic        invld_i;
    logic [15:0] iaddr_i;
    logic        read_o;
    logic        full_i;
    logic        ready_i;
    logic [15:0] addr_o;
    logic [31:0] data_i;

    icache_1way dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .init_no (init_no),
        .pc_i    (pc_i),
        .get_i   (get_i),
        .hit_o   (hit_o),
        .data_o  (data_o),
        .invld_i (invld_i),
        .iaddr_i (iaddr_i),
        .read_o  (read_o),
        .full_i  (full_i),
        .ready_i (ready_i),
        .addr_o  (addr_o),
        .data_i  (data_i)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_pass   = 0;
    int reads_seen = 0;
    bit hit_prev = 1'b0;
    bit gap_en = 1'b0;

    logic [31:0] exp_data_q[$];
    logic [15:0] exp_addr_q[$];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return ({16'h0, a} * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops and protocol checks on every event.
    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (read_o) begin
                reads_seen++;
                check("read_not_when_full", {31'b0, full_i}, 32'd0);
                check("read_expected", exp_addr_q.size(), 32'd1);
                if (exp_addr_q.size() > 0) begin
                    check("addr_o", {16'b0, addr_o}, {16'b0, exp_addr_q.pop_front()});
                end
            end
            if (hit_o) begin
                check("hit_not_with_read", {31'b0, read_o}, 32'd0);
                check("hit_not_consecutive", {31'b0, hit_prev}, 32'd0);
                check("hit_expected", {31'b0, (exp_data_q.size() > 0)}, 32'd1);
                if (exp_data_q.size() > 0) begin
                    check("data_o", data_o, exp_data_q.pop_front());
                end
            end
            if (!init_no && (hit_o || read_o)) begin
                check("quiet_during_init", {30'b0, hit_o, read_o}, 32'd0);
            end
            hit_prev = hit_o;
        end else begin
            hit_prev = 1'b0;
        end
    end

    // Memory model: answers each read_o with 16 beats starting next cycle.
    initial begin
        logic [15:0] base;
        ready_i = 1'b0;
        data_i  = '0;
        forever begin
            @(negedge clock_i);
            if (read_o && !reset_i) begin
                base = addr_o;
                for (int b = 0; b < 16; b++) begin
                    @(posedge clock_i);
                    #1;
                    if (reset_i) break;
                    check("addr_stable", {16'b0, addr_o}, {16'b0, base});
                    if (gap_en && (b % 4 == 1)) begin
                        ready_i = 1'b0;
                        data_i  = 32'hBAD0_0000 | b;
                        @(posedge clock_i);
                        #1;
                        if (reset_i) break;
                    end
                    ready_i = 1'b1;
                    data_i  = mem_word(base + 16'(b));
                end
                @(posedge clock_i);
                #1;
                ready_i = 1'b0;
                data_i  = 32'h5555_AAAA;
            end
        end
    end

    task automatic wait_init();
        int cnt;
        cnt = 0;
        @(negedge clock_i);
        while (init_no == 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clock_i);
        end
        check("init_ready", {31'b0, init_no}, 32'd1);
        check("init_len_ge64", {31'b0, (cnt >= 64)}, 32'd1);
    endtask

    task automatic invalidate(input logic [15:0] a);
        @(posedge clock_i);
        #1;
        invld_i = 1'b1;
        iaddr_i = a;
        @(posedge clock_i);
        #1;
        invld_i = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] pc, input bit exp_miss, input int full_cycles,
                         input bit gaps, input bit inv_lookup);
        int r0;
        int n;
        bit got;
        gap_en = gaps;
        r0 = reads_seen;
        @(posedge clock_i);
        #1;
        get_i = 1'b1;
        pc_i  = pc;
        if (full_cycles > 0) full_i = 1'b1;
        exp_data_q.push_back(mem_word(pc));
        if (exp_miss) exp_addr_q.push_back({pc[15:4], 4'h0});
        @(posedge clock_i);
        #1;
        get_i = 1'b0;
        pc_i  = 16'($urandom);
        n = 0;
        if (inv_lookup) begin
            invld_i = 1'b1;
            iaddr_i = pc;
            @(negedge clock_i);
            check("inv_forces_miss", {31'b0, hit_o}, 32'd0);
            @(posedge clock_i);
            #1;
            invld_i = 1'b0;
            n = 1;
        end
        if (full_cycles > 0) begin
            repeat (full_cycles - 1) @(posedge clock_i);
            #1;
            full_i = 1'b0;
            @(negedge clock_i);
            check("read_on_first_free", {31'b0, read_o}, 32'd1);
            n = full_cycles;
        end
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clock_i);
            if (hit_o) got = 1'b1;
            else n++;
        end
        check("hit_seen", {31'b0, got}, 32'd1);
        if (!got) begin
            exp_data_q.delete();
            exp_addr_q.delete();
        end
        if (full_cycles == 0 && !gaps) begin
            check("hit_latency", n, exp_miss ? 32'd18 : 32'd0);
        end
        check("read_count", reads_seen - r0, {31'b0, exp_miss});
    endtask

    initial begin
        reset_i = 1'b1;
        get_i   = 1'b0;
        pc_i    = '0;
        invld_i = 1'b0;
        iaddr_i = '0;
        full_i  = 1'b0;
        #2;
        check("rst_init_no", {31'b0, init_no}, 32'd0);
        check("rst_hit_o", {31'b0, hit_o}, 32'd0);
        check("rst_read_o", {31'b0, read_o}, 32'd0);
        check("rst_addr_o", {16'b0, addr_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        repeat (3) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        wait_init();

        // Cold miss, then a hit in the same line.
        fetch(16'h0014, 1'b1, 0, 1'b0, 1'b0);
        fetch(16'h0015, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check("data_hold", data_o, mem_word(16'h0015));

        // Conflict on the same index evicts the earlier line.
        fetch(16'h0414, 1'b1, 0, 1'b0, 1'b0);
        fetch(16'h0014, 1'b1, 0, 1'b0, 1'b0);

        // Matching invalidate drops the line; mismatching tag keeps it.
        invalidate(16'h0014);
        fetch(16'h0014, 1'b1, 0, 1'b0, 1'b0);
        invalidate(16'h0414);
        fetch(16'h0015, 1'b0, 0, 1'b0, 1'b0);

        // Memory busy for five cycles, then a hit in the filled line.
        fetch(16'h0827, 1'b1, 5, 1'b0, 1'b0);
        fetch(16'h0820, 1'b0, 0, 1'b0, 1'b0);

        // Gapped fill, then several words of the line.
        fetch(16'h0C3A, 1'b1, 0, 1'b1, 1'b0);
        fetch(16'h0C30, 1'b0, 0, 1'b0, 1'b0);
        fetch(16'h0C3F, 1'b0, 0, 1'b0, 1'b0);
        fetch(16'h0C35, 1'b0, 0, 1'b0, 1'b0);

        // Invalidate racing the lookup forces a miss.
        fetch(16'h0C3A, 1'b1, 0, 1'b0, 1'b1);
        fetch(16'h0C3A, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of a fill.
        gap_en = 1'b0;
        @(posedge clock_i);
        #1;
        get_i = 1'b1;
        pc_i  = 16'h1234;
        exp_addr_q.push_back(16'h1230);
        @(posedge clock_i);
        #1;
        get_i = 1'b0;
        repeat (8) @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_init_no", {31'b0, init_no}, 32'd0);
        check("mid_rst_addr_o", {16'b0, addr_o}, 32'd0);
        check("mid_rst_data_o", data_o, 32'd0);
        check("mid_rst_read_o", {31'b0, read_o}, 32'd0);
        repeat (3) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        wait_init();
        fetch(16'h0015, 1'b1, 0, 1'b0, 1'b0);
        fetch(16'h1234, 1'b1, 0, 1'b0, 1'b0);
        fetch(16'h1235, 1'b0, 0, 1'b0, 1'b0);

        repeat (4) @(posedge clock_i);
        check("data_queue_drained", exp_data_q.size(), 32'd0);
        check("addr_queue_drained", exp_addr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
